// File: rtl/led_ramp_monitor.sv
// Receive-side checker for the LED ramp/flick generator: tracks the expected count sequence, flags mismatches.
// Optional completed-cycle counter output cyc_cnt_o is enabled by defining LED_RAMP_MON_CYCLE_CNT_EN.
module led_ramp_monitor #(
  parameter int ERR_W = 8,
  parameter int CYC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_vld,
  input  logic [4:0]       count_in,
  input  logic             flick_in,
  output logic [2:0]       phase_o,
  output logic             locked_o,
  output logic             err_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic             done_o
`ifdef LED_RAMP_MON_CYCLE_CNT_EN
  ,
  output logic [CYC_W-1:0] cyc_cnt_o
`endif
);

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    UP15    = 3'd1,
    DN5     = 3'd2,
    UP10    = 3'd3,
    DN0     = 3'd4,
    UP5     = 3'd5,
    DN0_END = 3'd6,
    HUNT    = 3'd7
  } phase_t;

  phase_t           phase_r;
  phase_t           phase_nxt_s;
  phase_t           pred_phase_s;
  logic [4:0]       exp_r;
  logic [4:0]       exp_nxt_s;
  logic [4:0]       pred_exp_s;
  logic [4:0]       cnt_up_s;
  logic [4:0]       cnt_dn_s;
  logic             pred_done_s;
  logic             locked_r;
  logic             locked_nxt_s;
  logic             err_r;
  logic             err_nxt_s;
  logic             done_r;
  logic             done_nxt_s;
  logic [ERR_W-1:0] err_cnt_r;
  logic [ERR_W-1:0] err_cnt_nxt_s;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    if (v == {ERR_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(ERR_W-1){1'b0}}, 1'b1};
    end
  endfunction

  assign cnt_up_s = count_in + 5'd1;
  assign cnt_dn_s = count_in - 5'd1;

  // Prediction of the next phase/count from the current phase and the accepted sample.
  always_comb begin
    pred_phase_s = phase_r;
    pred_exp_s   = cnt_dn_s;
    pred_done_s  = 1'b0;
    case (phase_r)
      UP15: begin
        if (count_in < 5'd15) begin
          pred_phase_s = UP15;
          pred_exp_s   = cnt_up_s;
        end else begin
          pred_phase_s = DN5;
          pred_exp_s   = cnt_dn_s;
        end
      end
      DN5: begin
        if (count_in == 5'd4) begin
          pred_phase_s = flick_in ? UP15 : UP10;
          pred_exp_s   = cnt_up_s;
        end else begin
          pred_phase_s = DN5;
          pred_exp_s   = cnt_dn_s;
        end
      end
      UP10: begin
        if (count_in == 5'd10) begin
          pred_phase_s = DN0;
          pred_exp_s   = cnt_dn_s;
        end else begin
          pred_phase_s = UP10;
          pred_exp_s   = cnt_up_s;
        end
      end
      DN0: begin
        if (((count_in == 5'd4) || (count_in == 5'd0)) && flick_in) begin
          pred_phase_s = UP10;
          pred_exp_s   = cnt_up_s;
        end else if (count_in == 5'd0) begin
          pred_phase_s = UP5;
          pred_exp_s   = 5'd1;
        end else begin
          pred_phase_s = DN0;
          pred_exp_s   = cnt_dn_s;
        end
      end
      UP5: begin
        if (count_in == 5'd5) begin
          pred_phase_s = DN0_END;
          pred_exp_s   = cnt_dn_s;
        end else begin
          pred_phase_s = UP5;
          pred_exp_s   = cnt_up_s;
        end
      end
      DN0_END: begin
        if (count_in == 5'd0) begin
          pred_phase_s = INIT;
          pred_exp_s   = 5'd1;
          pred_done_s  = 1'b1;
        end else begin
          pred_phase_s = DN0_END;
          pred_exp_s   = cnt_dn_s;
        end
      end
      default: begin
        // INIT, and HUNT re-entry which behaves as INIT on the sample that re-locks.
        if (flick_in) begin
          pred_phase_s = UP15;
          pred_exp_s   = cnt_up_s;
        end else begin
          pred_phase_s = INIT;
          pred_exp_s   = 5'd0;
        end
      end
    endcase
  end

  // Step acceptance: compare against expectation, fall into HUNT on mismatch, re-lock on count 0.
  always_comb begin
    phase_nxt_s   = phase_r;
    exp_nxt_s     = exp_r;
    err_nxt_s     = 1'b0;
    done_nxt_s    = 1'b0;
    err_cnt_nxt_s = err_cnt_r;
    if (step_vld) begin
      if (phase_r == HUNT) begin
        if (count_in == 5'd0) begin
          phase_nxt_s = pred_phase_s;
          exp_nxt_s   = pred_exp_s;
        end else begin
          phase_nxt_s = HUNT;
          exp_nxt_s   = exp_r;
        end
      end else if (count_in != exp_r) begin
        phase_nxt_s   = HUNT;
        exp_nxt_s     = exp_r;
        err_nxt_s     = 1'b1;
        err_cnt_nxt_s = sat_inc(err_cnt_r);
      end else begin
        phase_nxt_s = pred_phase_s;
        exp_nxt_s   = pred_exp_s;
        done_nxt_s  = pred_done_s;
      end
    end else begin
      phase_nxt_s = phase_r;
      exp_nxt_s   = exp_r;
    end
    locked_nxt_s = (phase_nxt_s != HUNT);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r   <= INIT;
      exp_r     <= 5'd0;
      locked_r  <= 1'b1;
      err_r     <= 1'b0;
      done_r    <= 1'b0;
      err_cnt_r <= {ERR_W{1'b0}};
    end else begin
      phase_r   <= phase_nxt_s;
      exp_r     <= exp_nxt_s;
      locked_r  <= locked_nxt_s;
      err_r     <= err_nxt_s;
      done_r    <= done_nxt_s;
      err_cnt_r <= err_cnt_nxt_s;
    end
  end

  assign phase_o   = phase_r;
  assign locked_o  = locked_r;
  assign err_o     = err_r;
  assign done_o    = done_r;
  assign err_cnt_o = err_cnt_r;

`ifdef LED_RAMP_MON_CYCLE_CNT_EN
  logic [CYC_W-1:0] cyc_cnt_r;

  // Completed-cycle counter, wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt_r <= {CYC_W{1'b0}};
    end else if (done_nxt_s) begin
      cyc_cnt_r <= cyc_cnt_r + {{(CYC_W-1){1'b0}}, 1'b1};
    end else begin
      cyc_cnt_r <= cyc_cnt_r;
    end
  end

  assign cyc_cnt_o = cyc_cnt_r;
`endif

endmodule

// File: doc/led_ramp_monitor.md
Name: led_ramp_monitor

Overview:
- Receive-side checker for the LED ramp/flick sequence produced by the LED ramp generator FSM.
- Samples the generator's 5-bit brightness count and the flick input on each step strobe, and runs its own model of the sequence.
- Reports the decoded phase, flags every illegal step and counts errors.
- Sits beside the generator on the LED board path; used in silicon for self-check and in the bench as the scoreboard.

Parameters:
- ERR_W, 8, width of the saturating error counter.
- CYC_W, 8, width of the completed-cycle counter (optional feature only).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- step_vld  input  1  one-cycle strobe; count_in and flick_in are valid this cycle.
- count_in  input  5  generator current count.
- flick_in  input  1  flick level the generator uses for this step.
- phase_o  output  3  decoded phase: 0 INIT, 1 UP15, 2 DN5, 3 UP10, 4 DN0, 5 UP5, 6 DN0_END, 7 HUNT.
- locked_o  output  1  monitor is tracking the sequence (phase_o != HUNT).
- err_o  output  1  one-cycle pulse on a mismatched step.
- err_cnt_o  output  ERR_W  saturating count of mismatches.
- done_o  output  1  one-cycle pulse when DN0_END completes back to INIT.

Behaviour:
- Reset values: phase_o=INIT, exp_cnt=0, locked_o=1, err_o=0, err_cnt_o=0, done_o=0.
- Internal state: registered phase and exp_cnt (5 bits). Every output is registered and is valid the cycle after step_vld.
- No step_vld: all state holds; err_o and done_o are 0.
- On step_vld, when locked:
  - If count_in != exp_cnt: pulse err_o, err_cnt_o += 1 (saturates at all-ones), phase goes to HUNT. No prediction is made this step.
  - Otherwise compute next (phase, exp_cnt) from (phase, count_in=c, flick_in=f) with the rules below.
- Prediction rules:
  - INIT: f=1 gives UP15 with c+1. f=0 stays INIT with 0.
  - UP15: c<15 gives c+1. c>=15 gives DN5 with c-1.
  - DN5: c==4 gives UP15 with c+1 if f=1, else UP10 with c+1. Otherwise c-1.
  - UP10: c==10 gives DN0 with c-1. Otherwise c+1.
  - DN0: (c==4 or c==0) and f=1 gives UP10 with c+1. c==0 and f=0 gives UP5 with 1. Otherwise c-1.
  - UP5: c==5 gives DN0_END with c-1. Otherwise c+1.
  - DN0_END: c==0 gives INIT with exp 1 and pulses done_o. Otherwise c-1.
- In INIT the expected count after a completed cycle is 1, and the next INIT step then predicts 0 or 2 by flick. This matches the generator exactly.
- HUNT: on step_vld with count_in==0, go to INIT and predict from INIT with that sample (f=1 gives UP15/1, f=0 gives INIT/0). Other counts stay in HUNT with no error pulses.
- Arithmetic is 5-bit and wraps modulo 32. The generator never leaves 0..15, so any count_in >= 16 is a mismatch via exp compare.
- Asynchronous reset mid-sequence returns to INIT/exp 0 immediately. The generator is assumed to be reset by the same rst_n.

Optional Feature:
- Macro LED_RAMP_MON_CYCLE_CNT_EN.
- Defined: adds output port cyc_cnt_o [CYC_W-1:0], reset 0, incremented (wrapping) on each done_o pulse.
- Not defined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, then 3 steps count=0 flick=0 -> phase_o=INIT, err_o never set, err_cnt_o=0.
- Full nominal cycle: count 0 with flick=1, ramp to 15, down to 4 with flick=0, up to 10, down to 0 with flick=0, up to 5, down to 0 -> phases 1,2,3,4,5,6 in order, done_o pulses once after count 0 in DN0_END, no errors; with LED_RAMP_MON_CYCLE_CNT_EN, cyc_cnt_o=1.
- Re-entry: in DN5 at count 4 with flick=1 -> phase_o=UP15, next count 5 accepted. In DN0 at count 4 with flick=1 -> UP10, count 5 accepted.
- Corruption: in UP15 expecting 7, drive 9 -> err_o one cycle, err_cnt_o=1, phase_o=HUNT, locked_o=0. Then counts 8,3 -> no further errors. Then count 0 with flick=1 -> INIT, then UP15 expecting 1.
- Saturation with ERR_W=2: force 5 mismatches, each re-locking through count 0 between them -> err_cnt_o sticks at 3.
- Assert rst_n low mid-UP10 without a clock edge -> outputs return to reset values immediately. After release, count 0 accepted.
